// File: rtl/nand_pair_sweep.sv
// Registered NAND-pair/inhibit function F with an on-chip exhaustive sweep engine.
// Optional macro SWEEP_CHECK_EN adds expect_ones/pass to self-check the sweep result.
module nand_pair_sweep #(
  parameter int PAIRS = 2,
  parameter int HOLD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*PAIRS:0]   in_vec,
  input  logic               start,
`ifdef SWEEP_CHECK_EN
  input  logic [2*PAIRS+1:0] expect_ones,
  output logic               pass,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*PAIRS:0]   vec_out,
  output logic               f_out,
  output logic [2*PAIRS+1:0] ones_count
);
  localparam int N  = 2*PAIRS + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N:0]    CNT_LAST  = {1'b0, {N{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  // Bit 0 inhibits; pair i sits on bits [2i+2:2i+1].
  function automatic logic nand_f(input logic [N-1:0] v);
    logic f;
    f = ~v[0];
    for (int i = 0; i < PAIRS; i++) begin
      f = f & ~(v[2*i+1] & v[2*i+2]);
    end
    return f;
  endfunction

  state_t        state, state_nxt;
  logic [N:0]    cnt;
  logic [HW-1:0] hold;
  logic          f_cnt;
  logic          step;
  logic          last_step;
  logic [N:0]    ones_nxt;

  always_comb begin
    f_cnt     = nand_f(cnt[N-1:0]);
    step      = (hold == HOLD_LAST);
    last_step = step && (cnt == CNT_LAST);
    ones_nxt  = ones_count + {{N{1'b0}}, (f_cnt & step)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SWEEP;
      S_SWEEP: if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SWEEP);
    done = (state == S_DONE);
  end

  // Registered result stage: sweep counter drives the function while sweeping, in_vec otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out    <= '0;
      f_out      <= 1'b0;
      ones_count <= '0;
      cnt        <= '0;
      hold       <= '0;
`ifdef SWEEP_CHECK_EN
      pass       <= 1'b0;
`endif
    end else if (state == S_SWEEP) begin
      vec_out    <= cnt[N-1:0];
      f_out      <= f_cnt;
      ones_count <= ones_nxt;
      if (step) begin
        hold <= '0;
        cnt  <= cnt + (N+1)'(1);
      end else begin
        hold <= hold + HW'(1);
      end
`ifdef SWEEP_CHECK_EN
      if (last_step) pass <= (ones_nxt == expect_ones);
`endif
    end else begin
      vec_out <= in_vec;
      f_out   <= nand_f(in_vec);
      if ((state == S_IDLE) && start) begin
        cnt        <= '0;
        hold       <= '0;
        ones_count <= '0;
`ifdef SWEEP_CHECK_EN
        pass       <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_nand_pair_sweep.sv
// Bench for nand_pair_sweep: directed and random pass-through plus full sweeps at several sizes.
module tb_nand_pair_sweep;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] in_vec, vec_out;
  logic       start, busy, done, f_out;
  logic [5:0] ones_count;

  logic [4:0] h4_in, h4_vec;
  logic       h4_start, h4_busy, h4_done, h4_f;
  logic [5:0] h4_ones;

  logic [2:0] p1_in, p1_vec;
  logic       p1_start, p1_busy, p1_done, p1_f;
  logic [3:0] p1_ones;

  logic [6:0] p3_in, p3_vec;
  logic       p3_start, p3_busy, p3_done, p3_f;
  logic [7:0] p3_ones;

`ifdef SWEEP_CHECK_EN
  logic [5:0] expect_ones, h4_exp;
  logic [3:0] p1_exp;
  logic [7:0] p3_exp;
  logic       pass, h4_pass, p1_pass, p3_pass;
`endif

  nand_pair_sweep #(.PAIRS(2), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .start(start),
`ifdef SWEEP_CHECK_EN
    .expect_ones(expect_ones), .pass(pass),
`endif
    .busy(busy), .done(done), .vec_out(vec_out), .f_out(f_out), .ones_count(ones_count));

  nand_pair_sweep #(.PAIRS(2), .HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .in_vec(h4_in), .start(h4_start),
`ifdef SWEEP_CHECK_EN
    .expect_ones(h4_exp), .pass(h4_pass),
`endif
    .busy(h4_busy), .done(h4_done), .vec_out(h4_vec), .f_out(h4_f), .ones_count(h4_ones));

  nand_pair_sweep #(.PAIRS(1), .HOLD(1)) u_p1 (
    .clk(clk), .rst(rst), .in_vec(p1_in), .start(p1_start),
`ifdef SWEEP_CHECK_EN
    .expect_ones(p1_exp), .pass(p1_pass),
`endif
    .busy(p1_busy), .done(p1_done), .vec_out(p1_vec), .f_out(p1_f), .ones_count(p1_ones));

  nand_pair_sweep #(.PAIRS(3), .HOLD(1)) u_p3 (
    .clk(clk), .rst(rst), .in_vec(p3_in), .start(p3_start),
`ifdef SWEEP_CHECK_EN
    .expect_ones(p3_exp), .pass(p3_pass),
`endif
    .busy(p3_busy), .done(p3_done), .vec_out(p3_vec), .f_out(p3_f), .ones_count(p3_ones));

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference: F is 1 when the inhibit bit is clear and no pair has both bits set.
  function automatic int f_ref(input int v, input int pairs);
    if (v % 2 != 0) return 0;
    for (int i = 0; i < pairs; i++) begin
      if (((v >> (2*i+1)) & 3) == 3) return 0;
    end
    return 1;
  endfunction

  function automatic int count_ref(input int pairs);
    int c;
    c = 0;
    for (int v = 0; v < (1 << (2*pairs+1)); v++) c += f_ref(v, pairs);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_main();
    int done_at, done_n;
    done_at = -1;
    done_n  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sw_busy_start", busy, 1);
`ifdef SWEEP_CHECK_EN
    chk("pass_clear", pass, 0);
`endif
    for (int e = 1; e <= 36; e++) begin
      start  = (e == 12 || e == 33);
      in_vec = 5'($urandom);
      tick();
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = e;
      end
      if (e <= 32) begin
        chk("sw_vec", vec_out, e - 1);
        chk("sw_f", f_out, f_ref(e - 1, 2));
        chk("sw_busy", busy, (e < 32) ? 1 : 0);
      end else begin
        chk("post_busy", busy, 0);
        chk("post_vec", vec_out, in_vec);
        chk("post_f", f_out, f_ref(int'(in_vec), 2));
      end
      if (e >= 32) chk("ones_held", ones_count, count_ref(2));
    end
    start = 1'b0;
    chk("sw_done_edge", done_at, 32);
    chk("sw_done_once", done_n, 1);
`ifdef SWEEP_CHECK_EN
    chk("pass_result", pass, (int'(expect_ones) == count_ref(2)) ? 1 : 0);
`endif
  endtask

  initial begin
    logic [4:0] dv [5];
    logic       de [5];
    int v, done_at, p1_at, p3_at;
    dv = '{5'b00000, 5'b00001, 5'b11000, 5'b10100, 5'b00110};
    de = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0; h4_start = 1'b0; p1_start = 1'b0; p3_start = 1'b0;
    in_vec = '0; h4_in = '0; p1_in = '0; p3_in = '0;
`ifdef SWEEP_CHECK_EN
    expect_ones = 6'd9;
    h4_exp = 6'(count_ref(2));
    p1_exp = 4'(count_ref(1));
    p3_exp = 8'(count_ref(3));
`endif
    in_vec = 5'b00000;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_f", f_out, 0);
    chk("rst_ones", ones_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      in_vec = dv[i];
      tick();
      chk("idle_f", f_out, de[i]);
      chk("idle_vec", vec_out, dv[i]);
    end
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(0, 31);
      in_vec = 5'(v);
      tick();
      chk("rand_f", f_out, f_ref(v, 2));
      chk("rand_vec", vec_out, v);
    end

    sweep_main();
`ifdef SWEEP_CHECK_EN
    expect_ones = 6'd8;
    sweep_main();
`endif

    // HOLD=4: each vector held four cycles, a mid-sweep start must not disturb anything.
    done_at = -1;
    h4_start = 1'b1;
    tick();
    h4_start = 1'b0;
    for (int e = 1; e <= 132; e++) begin
      h4_start = (e == 50);
      h4_in = 5'($urandom);
      tick();
      if (h4_done && done_at < 0) done_at = e;
      if (e <= 128) begin
        chk("h4_vec", h4_vec, (e - 1) / 4);
        chk("h4_f", h4_f, f_ref((e - 1) / 4, 2));
        chk("h4_busy", h4_busy, (e < 128) ? 1 : 0);
      end
    end
    h4_start = 1'b0;
    chk("h4_done_edge", done_at, 128);
    chk("h4_ones", h4_ones, count_ref(2));
`ifdef SWEEP_CHECK_EN
    chk("h4_pass", h4_pass, 1);
`endif

    p1_at = -1;
    p3_at = -1;
    p1_start = 1'b1;
    p3_start = 1'b1;
    tick();
    p1_start = 1'b0;
    p3_start = 1'b0;
    for (int e = 1; e <= 132; e++) begin
      tick();
      if (p1_done && p1_at < 0) p1_at = e;
      if (p3_done && p3_at < 0) p3_at = e;
      if (e <= 8) begin
        chk("p1_vec", p1_vec, e - 1);
        chk("p1_f", p1_f, f_ref(e - 1, 1));
        chk("p1_busy", p1_busy, (e < 8) ? 1 : 0);
      end
      if (e <= 128) begin
        chk("p3_vec", p3_vec, e - 1);
        chk("p3_f", p3_f, f_ref(e - 1, 3));
        chk("p3_busy", p3_busy, (e < 128) ? 1 : 0);
      end
    end
    chk("p1_done_edge", p1_at, 8);
    chk("p3_done_edge", p3_at, 128);
    chk("p1_ones", p1_ones, count_ref(1));
    chk("p3_ones", p3_ones, count_ref(3));
`ifdef SWEEP_CHECK_EN
    chk("p1_pass", p1_pass, 1);
    chk("p3_pass", p3_pass, 1);
    expect_ones = 6'd9;
`endif

    // Asynchronous reset in the middle of a sweep, then a full sweep again.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    chk("mid_vec_pre", vec_out, 9);
    chk("mid_ones_pre", ones_count, count_ref(0) + 3);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_vec", vec_out, 0);
    chk("mid_rst_f", f_out, 0);
    chk("mid_rst_ones", ones_count, 0);
`ifdef SWEEP_CHECK_EN
    chk("mid_rst_pass", pass, 0);
`endif
    tick();
    rst = 1'b0;
    in_vec = 5'b00110;
    tick();
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_f", f_out, 0);
    sweep_main();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
